// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, one data byte, STOP.
// Open-drain bus outputs are registered; a high *_oe pulls the line low.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA,
    WACK, RDATA, RACK, STOP, DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  qcnt;
  logic [1:0]  phase;
  logic [2:0]  bcnt;
  logic [6:0]  addr;
  logic        rw;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [7:0]  abyte;
  logic        nack;
  logic        accept;
  logic        tick;
  logic        bit_end;
  logic        byte_end;
  logic        samp;
  logic        shift_st;
  logic        tx_bit;
  logic        scl_n;
  logic        sda_n;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (qcnt == 8'(CLK_DIV - 1));
  assign bit_end   = tick && (phase == 2'd3);
  assign byte_end  = bit_end && (bcnt == 3'd7);
  assign samp      = (phase == 2'd3) && (qcnt == 8'd0);
  assign shift_st  = (state == ADDR) || (state == WDATA)
                  || (state == RDATA);
  assign abyte     = {addr, rw};
  assign tx_bit    = (state == ADDR) ? abyte[~bcnt]
                                     : wdata[~bcnt];

  always_comb begin
    state_n = state;
    scl_n   = 1'b0;
    sda_n   = 1'b0;
    unique case (state)
      IDLE:     if (cmd_valid) state_n = START;
      START: begin
        scl_n = (phase == 2'd3);
        sda_n = phase[1];
        if (bit_end) state_n = ADDR;
      end
      ADDR: begin
        scl_n = ~phase[1];
        sda_n = ~tx_bit;
        if (byte_end) state_n = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_n = ~phase[1];
        if (bit_end) begin
          if (nack)    state_n = STOP;
          else if (rw) state_n = RDATA;
          else         state_n = WDATA;
        end
      end
      WDATA: begin
        scl_n = ~phase[1];
        sda_n = ~tx_bit;
        if (byte_end) state_n = WACK;
      end
      WACK: begin
        scl_n = ~phase[1];
        if (bit_end) state_n = STOP;
      end
      RDATA: begin
        scl_n = ~phase[1];
        if (byte_end) state_n = RACK;
      end
      RACK: begin
        // single-byte read: master answers NACK
        scl_n = ~phase[1];
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        scl_n = (phase == 2'd0);
        sda_n = ~phase[1];
        if (bit_end) state_n = DONE;
      end
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      qcnt      <= '0;
      phase     <= '0;
      bcnt      <= '0;
      addr      <= '0;
      rw        <= 1'b0;
      wdata     <= '0;
      rdata     <= '0;
      nack      <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      state     <= state_n;
      scl_oe    <= scl_n;
      sda_oe    <= sda_n;
      rsp_valid <= (state == DONE);
      if (state == IDLE || state == DONE) begin
        qcnt  <= '0;
        phase <= '0;
        bcnt  <= '0;
      end else if (tick) begin
        qcnt  <= '0;
        phase <= phase + 2'd1;
        if (bit_end && shift_st) bcnt <= bcnt + 3'd1;
      end else begin
        qcnt <= qcnt + 8'd1;
      end
      if (accept) begin
        addr      <= cmd_addr;
        rw        <= cmd_rw;
        wdata     <= cmd_wdata;
        rdata     <= '0;
        nack      <= 1'b0;
        rsp_rdata <= '0;
        rsp_nack  <= 1'b0;
      end
      if (samp) begin
        unique case (state)
          ADDR_ACK, WACK: nack  <= sda_in;
          RDATA:          rdata <= {rdata[6:0], sda_in};
          default: ;
        endcase
      end
      if (state == DONE) begin
        rsp_rdata <= rdata;
        rsp_nack  <= nack;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus monitor, slave model
// and a transaction-level reference model.
module tb_i2c_master_ctrl;

  localparam int         D   = 4;
  localparam logic [6:0] DEV = 7'h2A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;
  logic       slave_sda = 1'b1;

  assign sda_in = ~sda_oe & slave_sda;

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .busy(busy),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc = 0;
  int exp_starts = 0;
  int exp_stops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // slave configuration
  logic       present = 1'b1;
  logic       ack_data = 1'b1;
  logic [7:0] rd_byte = 8'h00;

  // bus monitor and slave
  logic pscl = 1'b1;
  logic psda = 1'b1;
  bit   q[$];
  int   starts = 0;
  int   stops = 0;
  logic sl_ack = 1'b0;
  logic sl_rd = 1'b0;

  always @(negedge clk) begin
    logic scl_v, sda_v, nx;
    logic [7:0] ab;
    int nb;
    scl_v = ~scl_oe;
    sda_v = sda_in;
    if (!rst_n) begin
      slave_sda = 1'b1;
    end else begin
      if (pscl && scl_v && psda && !sda_v) begin
        starts++;
        q.delete();
        sl_ack = 1'b0;
      end else if (pscl && scl_v && !psda && sda_v) begin
        stops++;
        if (q.size() > 0) void'(q.pop_back());
      end
      if (!pscl && scl_v) q.push_back(sda_v);
      if (pscl && !scl_v) begin
        nx = 1'b1;
        nb = q.size();
        if (nb == 8) begin
          ab = '0;
          for (int i = 0; i < 8; i++) ab = {ab[6:0], q[i]};
          sl_ack = present && (ab[7:1] == DEV);
          sl_rd  = ab[0];
          nx = ~sl_ack;
        end else if (sl_ack && sl_rd && nb >= 9 && nb <= 16) begin
          nx = rd_byte[16 - nb];
        end else if (sl_ack && !sl_rd && nb == 17) begin
          nx = ~ack_data;
        end
        slave_sda = nx;
      end
    end
    pscl = scl_v;
    psda = sda_v;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected SDA stream, nack and read data for one transaction
  function automatic int model(input logic [6:0] a,
                               input logic r,
                               input logic [7:0] w,
                               output logic [17:0] s,
                               output logic nk,
                               output logic [7:0] rd_o);
    logic acked;
    logic [7:0] b;
    int n;
    acked = present && (a == DEV);
    s = '0;
    n = 0;
    b = {a, r};
    for (int i = 7; i >= 0; i--) begin
      s = {s[16:0], b[i]};
      n++;
    end
    s = {s[16:0], ~acked};
    n++;
    nk = ~acked;
    rd_o = '0;
    if (acked) begin
      b = r ? rd_byte : w;
      for (int i = 7; i >= 0; i--) begin
        s = {s[16:0], b[i]};
        n++;
      end
      if (r) begin
        s = {s[16:0], 1'b1};
        rd_o = rd_byte;
      end else begin
        s = {s[16:0], ~ack_data};
        nk = ~ack_data;
      end
      n++;
    end
    return n;
  endfunction

  task automatic issue(input logic [6:0] a, input logic r,
                       input logic [7:0] w, input bit hold);
    int n;
    @(negedge clk);
    cmd_addr = a;
    cmd_rw = r;
    cmd_wdata = w;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 100), 1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    if (!hold) cmd_valid = 1'b0;
    exp_starts++;
    chk("busy_on", busy, 1);
    chk("ready_off", cmd_ready, 0);
    chk("nack_clr", rsp_nack, 0);
    chk("rdata_clr", rsp_rdata, 0);
  endtask

  task automatic finish(input logic [6:0] a, input logic r,
                        input logic [7:0] w, output int rcyc);
    logic [17:0] es, gs;
    logic enk;
    logic [7:0] erd;
    int en, n;
    en = model(a, r, w, es, enk, erd);
    n = 0;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", 32'(rsp_valid), 1);
    rcyc = cyc;
    exp_stops++;
    chk("latency", rcyc - acc, 1 + (8 + 4 * en) * D);
    chk("rsp_nack", rsp_nack, enk);
    chk("rsp_rdata", rsp_rdata, erd);
    gs = '0;
    foreach (q[i]) gs = {gs[16:0], q[i]};
    chk("bit_count", q.size(), en);
    chk("bit_stream", gs, es);
    chk("starts", starts, exp_starts);
    chk("stops", stops, exp_stops);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
    chk("rsp_hold", rsp_nack, enk);
  endtask

  initial begin
    int r1, r2, n, pulses;
    logic [6:0] ra;
    logic rr;
    logic [7:0] rw_b;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_rw = 1'b0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_nack", rsp_nack, 0);
    rst_n = 1'b1;

    // write, both bytes acked
    issue(DEV, 1'b0, 8'hC3, 0);
    finish(DEV, 1'b0, 8'hC3, r1);
    // address NACK
    issue(7'h10, 1'b0, 8'h77, 0);
    finish(7'h10, 1'b0, 8'h77, r1);
    // read
    rd_byte = 8'h5A;
    issue(DEV, 1'b1, 8'h00, 0);
    finish(DEV, 1'b1, 8'h00, r1);
    // write-data NACK
    ack_data = 1'b0;
    issue(DEV, 1'b0, 8'hFF, 0);
    finish(DEV, 1'b0, 8'hFF, r1);
    ack_data = 1'b1;

    // back-to-back with cmd_valid held
    rd_byte = 8'h96;
    issue(DEV, 1'b0, 8'h3C, 1);
    cmd_rw = 1'b1;
    cmd_wdata = 8'hE1;
    finish(DEV, 1'b0, 8'h3C, r1);
    acc = cyc;
    chk("b2b_accept", acc, r1 + 1);
    chk("b2b_busy", busy, 1);
    cmd_valid = 1'b0;
    exp_starts++;
    finish(DEV, 1'b1, 8'hE1, r2);

    // reset during address bit 3
    issue(DEV, 1'b0, 8'hA5, 0);
    n = 0;
    while (!(q.size() == 3 && scl_oe) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("bit3_seen", 32'(n < 500), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_scl", scl_oe, 0);
    chk("arst_sda", sda_oe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (400) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("arst_no_rsp", pulses, 0);
    chk("arst_no_stop", stops, exp_stops);
    issue(DEV, 1'b0, 8'h81, 0);
    finish(DEV, 1'b0, 8'h81, r1);

    // randomized transactions
    for (int k = 0; k < 6; k++) begin
      ra = $urandom_range(0, 1) ? DEV : 7'($urandom);
      rr = 1'($urandom);
      rw_b = 8'($urandom);
      rd_byte = 8'($urandom);
      ack_data = 1'($urandom);
      issue(ra, rr, rw_b, 0);
      finish(ra, rr, rw_b, r1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-byte I2C master sequencer that drives the bus for the team's i2c slave blocks.
- Accepts one command per transaction: 7-bit target address, R/W bit and write byte.
- Generates START, address+R/W, ACK sampling, one data byte (write or read), master ACK/NACK and STOP.
- Returns read data and ACK status over a response strobe.
- Open-drain bus: the block only ever pulls low or releases.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-period; legal range 2..255. One SCL bit = 4*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE
- cmd_addr  input  7  target slave address
- cmd_rw  input  1  1 = read, 0 = write
- cmd_wdata  input  8  byte to write; ignored on reads
- rsp_valid  output  1  one-cycle pulse at transaction end
- rsp_rdata  output  8  byte read; 0 for writes or address NACK
- rsp_nack  output  1  1 if address or write-data byte was NACKed
- busy  output  1  high from command accept through STOP completion
- scl_oe  output  1  1 = pull SCL low
- sda_oe  output  1  1 = pull SDA low
- sda_in  input  1  sampled SDA line

Behaviour:
- Reset (rst_n low, any state, asynchronous): state IDLE; scl_oe=0, sda_oe=0 (bus released); cmd_ready=1; busy=0; rsp_valid=0; rsp_rdata=0; rsp_nack=0; quarter counter and bit counter cleared.
- Reset mid-transaction: abandons the transfer with no STOP generated and no rsp_valid pulse.
- Handshake:
  - Command accepted on the clk edge where cmd_valid && cmd_ready.
  - cmd_addr, cmd_rw and cmd_wdata are latched on that edge.
  - cmd_ready drops the next cycle; busy rises the same cycle.
- Timing engine: quarter counter 0..CLK_DIV-1; a quarter tick advances the phase q0..q3.
- Standard bit phases:
  - q0/q1: SCL low; SDA updated at q0 entry.
  - q2/q3: SCL released.
  - SDA sampled at the first clk of q3.
- States and transitions:
  - IDLE -> START on accept.
  - START (4Q): q0-q1 both released; q2 SDA low with SCL high; q3 SCL low.
  - ADDR: 8 bits MSB-first, {addr[6:0], rw}.
  - ADDR_ACK: 1 bit, SDA released, sample sda_in. If 1: set nack and go to STOP. Else go to WDATA if rw=0, RDATA if rw=1.
  - WDATA: 8 bits MSB-first.
  - WACK: sample; sda_in=1 sets nack. Then STOP.
  - RDATA: SDA released; 8 bits shifted into rdata MSB-first.
  - RACK: master drives NACK (SDA released), since this is a single-byte read. Then STOP.
  - STOP (4Q): q0 SCL low, SDA low; q1 SCL high, SDA low; q2 SDA released; q3 hold.
  - DONE: 1 cycle; rsp_valid=1 with rsp_rdata/rsp_nack. Then IDLE, cmd_ready=1 next cycle.
- Latency from accept to rsp_valid:
  - Full transaction: 1 + 80*CLK_DIV clk cycles (START 4Q + 9 bits 36Q + 9 bits 36Q + STOP 4Q).
  - Address NACK: 1 + 44*CLK_DIV clk cycles.
- rsp_rdata and rsp_nack hold their values until the next rsp_valid. Both are cleared at accept of a new command.
- cmd_valid while busy is ignored; there is no queueing.
- Bit counter is 3 bits and wraps 7->0 at each byte boundary.
- Clock stretching is not supported: the slave holding SCL low is not detected, and the block does not sample scl.
- Arbitration loss is not detected.
- Glitch-free outputs: scl_oe and sda_oe are registered. SDA never changes while SCL is released, except in START q2 and STOP q2.

Test Plan:
- Write, ACK: CLK_DIV=4, addr=0x2A, rw=0, wdata=0xC3; slave model ACKs both bytes -> SDA bit stream 0x54 then 0xC3; rsp_valid exactly 321 cycles after accept; rsp_nack=0; rsp_rdata=0.
- Address NACK: addr=0x10, no device (sda_in pulled high) -> no data phase; STOP follows; rsp_valid at 177 cycles; rsp_nack=1.
- Read: addr=0x2A, rw=1; slave returns 0x5A -> address byte 0x55; rsp_rdata=0x5A; master SDA released on 9th clock (NACK); rsp_nack=0.
- Back-to-back: cmd_valid held high with two commands -> second accepted exactly 1 cycle after first rsp_valid; cmd_valid during busy ignored; START/STOP conditions verified by a bus monitor checking SDA edges only while SCL is high.
- Reset mid-ADDR: rst_n low at bit 3 -> scl_oe=sda_oe=0 immediately (asynchronous); no rsp_valid; next command completes normally.
- Write-data NACK: slave ACKs address 0x2A but NACKs wdata 0xFF -> rsp_nack=1; STOP generated; latency 321 cycles.
